mux_rr_stage: RTL

Registered two-input arbitrating multiplexer sitting directly upstream of the 2:1 mux/demux path: it feeds the mux data and select, and turns it into a flow-controlled stage. Two sources with valid/ready handshakes compete for one output. A round-robin pointer resolves conflicts. The winner is captured in a single output register together with the select value that produced it. Saturating per-source grant counters provide link statistics.

---
 rtl/mux_pkg.sv | 10 +
 rtl/sat_counter.sv | 21 ++
 rtl/mux_rr_stage.sv | 80 ++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux stage.
package mux_pkg;

    // One-bit source select; the encoding is what the downstream mux/demux sees.
    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Count handshakes, stopping at the all-ones value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mux_rr_stage.sv
// Two-source round-robin arbiter feeding a single registered output word
// plus the select that produced it, with per-source grant statistics.
module mux_rr_stage
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_sel,
    input  logic             y_ready,
    input  logic             cnt_clr,
    output logic [CW-1:0]    cnt_a,
    output logic [CW-1:0]    cnt_b
);

    sel_t prio;
    sel_t grant_sel;
    logic grant_vld;
    logic load;

    // Grant decision: a lone requester wins, a conflict goes to the preferred source.
    always_comb begin
        grant_vld = a_valid || b_valid;
        grant_sel = SEL_A;
        if (a_valid && b_valid) begin
            grant_sel = prio;
        end else if (b_valid) begin
            grant_sel = SEL_B;
        end
        load    = !y_valid || y_ready;
        a_ready = load && a_valid && (grant_sel == SEL_A);
        b_ready = load && b_valid && (grant_sel == SEL_B);
    end

    // Output register and priority pointer; the loser of a conflict is preferred next.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_sel   <= SEL_A;
            prio    <= SEL_A;
        end else if (load) begin
            if (grant_vld) begin
                y_valid <= 1'b1;
                y_data  <= (grant_sel == SEL_B) ? b_data : a_data;
                y_sel   <= grant_sel;
                prio    <= (grant_sel == SEL_A) ? SEL_B : SEL_A;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

    sat_counter #(.CW(CW)) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (a_ready),
        .count (cnt_a)
    );

    sat_counter #(.CW(CW)) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (b_ready),
        .count (cnt_b)
    );

endmodule
